// File: rtl/ide_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ide_reset_sequencer
// Brief    : Device-side ATA post-reset sequencer. Holds BSY while a hardware
//            or software reset is asserted, pulses the signature load on
//            entry to the diagnostic interval, then publishes the diagnostic
//            code and releases BSY with DRDY set.
// Revision : 1.0 - initial release
// ============================================================================
module ide_reset_sequencer #(
    parameter int unsigned DIAG_CYCLES = 32'h0000_0400,
    parameter int unsigned CNT_W       = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ide_rst,
    input  logic       srst,
    input  logic       diag_fail,
    output logic       bsy,
    output logic       drdy,
    output logic       sig_load,
    output logic [7:0] diag_code,
    output logic       hw_reset,
    output logic       reset_done
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_DIAG  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Counter value on the final diagnostic cycle.
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DIAG_CYCLES - 1);

    state_t           r_state_q,      w_state_d;
    logic [CNT_W-1:0] r_cnt_q,        w_cnt_d;
    logic             r_bsy_q,        w_bsy_d;
    logic             r_drdy_q,       w_drdy_d;
    logic             r_sig_load_q,   w_sig_load_d;
    logic             r_reset_done_q, w_reset_done_d;
    logic             r_hw_reset_q,   w_hw_reset_d;
    logic [7:0]       r_diag_code_q,  w_diag_code_d;

    logic             w_any_rst;

    assign w_any_rst = ide_rst | srst;

    // Next-state and next-output computation for the reset protocol.
    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_bsy_d        = r_bsy_q;
        w_drdy_d       = r_drdy_q;
        w_sig_load_d   = 1'b0;
        w_reset_done_d = 1'b0;
        w_diag_code_d  = r_diag_code_q;
        // Track the source of the most recent reset; hardware wins a tie.
        if (ide_rst) begin
            w_hw_reset_d = 1'b1;
        end else if (srst) begin
            w_hw_reset_d = 1'b0;
        end else begin
            w_hw_reset_d = r_hw_reset_q;
        end

        case (r_state_q)
            ST_HOLD: begin
                w_bsy_d  = 1'b1;
                w_drdy_d = 1'b0;
                w_cnt_d  = '0;
                if (!w_any_rst) begin
                    w_state_d    = ST_DIAG;
                    w_sig_load_d = 1'b1;
                end
            end
            ST_DIAG: begin
                w_bsy_d  = 1'b1;
                w_drdy_d = 1'b0;
                if (w_any_rst) begin
                    // Abort: restart the whole sequence once resets drop.
                    w_state_d = ST_HOLD;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == C_LAST_CNT) begin
                    w_state_d      = ST_READY;
                    w_cnt_d        = '0;
                    w_bsy_d        = 1'b0;
                    w_drdy_d       = 1'b1;
                    w_reset_done_d = 1'b1;
                    w_diag_code_d  = diag_fail ? 8'h00 : 8'h01;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                w_bsy_d  = 1'b0;
                w_drdy_d = 1'b1;
                if (w_any_rst) begin
                    w_state_d = ST_HOLD;
                    w_bsy_d   = 1'b1;
                    w_drdy_d  = 1'b0;
                end
            end
            default: begin
                w_state_d = ST_HOLD;
                w_cnt_d   = '0;
                w_bsy_d   = 1'b1;
                w_drdy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; global reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_HOLD;
            r_cnt_q        <= '0;
            r_bsy_q        <= 1'b1;
            r_drdy_q       <= 1'b0;
            r_sig_load_q   <= 1'b0;
            r_reset_done_q <= 1'b0;
            r_hw_reset_q   <= 1'b1;
            r_diag_code_q  <= 8'h00;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_bsy_q        <= w_bsy_d;
            r_drdy_q       <= w_drdy_d;
            r_sig_load_q   <= w_sig_load_d;
            r_reset_done_q <= w_reset_done_d;
            r_hw_reset_q   <= w_hw_reset_d;
            r_diag_code_q  <= w_diag_code_d;
        end
    end

    assign bsy        = r_bsy_q;
    assign drdy       = r_drdy_q;
    assign sig_load   = r_sig_load_q;
    assign reset_done = r_reset_done_q;
    assign hw_reset   = r_hw_reset_q;
    assign diag_code  = r_diag_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ide_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ide_reset_sequencer
// Brief    : Self-checking bench for ide_reset_sequencer. Two instances run in
//            lockstep (8-cycle and 1-cycle diagnostic interval) against a
//            reference model that counts clean edges since the last reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ide_reset_sequencer;

    logic clk;
    logic rst;
    logic ide_rst;
    logic srst;
    logic diag_fail;

    logic       a_bsy, a_drdy, a_sig_load, a_hw_reset, a_reset_done;
    logic [7:0] a_diag_code;
    logic       b_bsy, b_drdy, b_sig_load, b_hw_reset, b_reset_done;
    logic [7:0] b_diag_code;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;

    ide_reset_sequencer #(.DIAG_CYCLES(8), .CNT_W(21)) dut_a (
        .clk(clk), .rst(rst), .ide_rst(ide_rst), .srst(srst),
        .diag_fail(diag_fail), .bsy(a_bsy), .drdy(a_drdy),
        .sig_load(a_sig_load), .diag_code(a_diag_code),
        .hw_reset(a_hw_reset), .reset_done(a_reset_done)
    );

    ide_reset_sequencer #(.DIAG_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ide_rst(ide_rst), .srst(srst),
        .diag_fail(diag_fail), .bsy(b_bsy), .drdy(b_drdy),
        .sig_load(b_sig_load), .diag_code(b_diag_code),
        .hw_reset(b_hw_reset), .reset_done(b_reset_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected outputs follow from the number of consecutive
    // reset-free edges since the last sampled reset of any kind.
    int         m_diag[2] = '{8, 1};
    int         m_quiet[2];
    logic [7:0] m_code[2];
    logic       m_hw;
    logic [12:0] m_exp[2];   // {bsy, drdy, sig_load, reset_done, hw_reset, code}
    logic [25:0] exp_v;

    function automatic logic [25:0] obs_vec();
        return {a_bsy, a_drdy, a_sig_load, a_reset_done, a_hw_reset, a_diag_code,
                b_bsy, b_drdy, b_sig_load, b_reset_done, b_hw_reset, b_diag_code};
    endfunction

    // Apply one edge of stimulus, advance the model, settle past the edge.
    task automatic step(input logic r, input logic i, input logic s, input logic f);
        logic eb, ed, es, ek;
        rst = r; ide_rst = i; srst = s; diag_fail = f;
        @(posedge clk);
        edge_no++;
        if (r)      m_hw = 1'b1;
        else if (i) m_hw = 1'b1;
        else if (s) m_hw = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (r || i || s) begin
                m_quiet[k] = 0;
                if (r) m_code[k] = 8'h00;
                eb = 1'b1; ed = 1'b0; es = 1'b0; ek = 1'b0;
            end else begin
                if (m_quiet[k] < 1000) m_quiet[k]++;
                es = (m_quiet[k] == 1);
                ek = (m_quiet[k] == m_diag[k] + 1);
                if (ek) m_code[k] = f ? 8'h00 : 8'h01;
                eb = (m_quiet[k] <= m_diag[k]);
                ed = !eb;
            end
            m_exp[k] = {eb, ed, es, ek, m_hw, m_code[k]};
        end
        exp_v = {m_exp[0], m_exp[1]};
        #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            step(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            n_tests++;
            if (obs_vec() !== exp_v || a_bsy !== 1'b1 || a_diag_code !== 8'h00) begin
                n_fail++;
                $display("FAIL reset edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
            end
        end
    endtask

    task automatic test_hw_reset();
        for (int n = 0; n < 22; n++) begin
            step(1'b0, n < 10, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_v) begin
                n_fail++;
                $display("FAIL hw_reset edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
            end
        end
        n_tests++;
        if (a_diag_code !== 8'h01 || a_hw_reset !== 1'b1 || a_drdy !== 1'b1) begin
            n_fail++;
            $display("FAIL hw_reset_final got code=%h hw=%b drdy=%b exp code=01 hw=1 drdy=1",
                     a_diag_code, a_hw_reset, a_drdy);
        end
    endtask

    task automatic test_srst_from_ready();
        for (int n = 0; n < 15; n++) begin
            step(1'b0, 1'b0, n < 3, $urandom_range(0, 1));
            n_tests++;
            if (obs_vec() !== exp_v) begin
                n_fail++;
                $display("FAIL srst_ready edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
            end
        end
        n_tests++;
        if (a_hw_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_hw_flag got=%b exp=0", a_hw_reset);
        end
    endtask

    task automatic test_abort_diag();
        // Enter DIAG, abort on the fourth DIAG cycle, then run to READY.
        for (int n = 0; n < 20; n++) begin
            step(1'b0, n == 0, (n == 4) || (n == 5), 1'b0);
            n_tests++;
            if (obs_vec() !== exp_v) begin
                n_fail++;
                $display("FAIL abort_diag edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
            end
        end
    endtask

    task automatic test_diag_fail();
        // Random diag_fail everywhere except forced high on the 8-cycle final DIAG edge.
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 14; n++) begin
                step(1'b0, n < 2, 1'b0, (n == 10) ? (pass == 0) : 1'($urandom_range(0, 1)));
                n_tests++;
                if (obs_vec() !== exp_v) begin
                    n_fail++;
                    $display("FAIL diag_fail edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int n = 0; n < 18; n++) begin
            step(1'b0, n < 3, n < 5, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_v) begin
                n_fail++;
                $display("FAIL simultaneous edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
            end
        end
    endtask

    task automatic test_rst_priority();
        // Model left both instances in READY; rst must win on the same edge.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (obs_vec() !== exp_v || a_sig_load !== 1'b0 || a_hw_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_priority got=%h exp=%h", obs_vec(), exp_v);
        end
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_v) begin
                n_fail++;
                $display("FAIL rst_recover edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
            end
        end
    endtask

    task automatic test_random();
        int   left = 0;
        logic ri = 1'b0, rs = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (left > 0) begin
                left--;
            end else if ($urandom_range(0, 11) == 0) begin
                left = $urandom_range(0, 3);
                ri = 1'($urandom_range(0, 1));
                rs = ri ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                ri = 1'b0; rs = 1'b0;
            end
            step($urandom_range(0, 99) == 0, ri, rs, 1'($urandom_range(0, 1)));
            n_tests++;
            if (obs_vec() !== exp_v) begin
                n_fail++;
                $display("FAIL random edge=%0d got=%h exp=%h", edge_no, obs_vec(), exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; ide_rst = 1'b0; srst = 1'b0; diag_fail = 1'b0;
        m_hw = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_quiet[k] = 0;
            m_code[k]  = 8'h00;
        end
        @(negedge clk);
        test_reset();
        test_hw_reset();
        test_srst_from_ready();
        test_abort_diag();
        test_diag_fail();
        test_simultaneous();
        test_rst_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired at edge=%0d", edge_no);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
